// File: rtl/rv32_pkg.sv
// Shared RV32 memory-stage types: op codes, FSM states and op decode helpers.
package rv32_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LH   = 4'd2,
        LW   = 4'd3,
        LBU  = 4'd4,
        LHU  = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    function automatic logic is_load(mem_op_e op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic is_store(mem_op_e op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic logic is_half(mem_op_e op);
        return op inside {LH, LHU, SH};
    endfunction

    function automatic logic is_word(mem_op_e op);
        return op inside {LW, SW};
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of the returned bus word.
module load_align
    import rv32_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            addr,
    input  mem_op_e               op,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = rdata[{addr, 3'b000} +: 8];
        h    = rdata[{addr[1], 4'b0000} +: 16];
        data = rdata;
        unique case (op)
            LB:      data = {{(DATA_WIDTH-8){b[7]}}, b};
            LBU:     data = {{(DATA_WIDTH-8){1'b0}}, b};
            LH:      data = {{(DATA_WIDTH-16){h[15]}}, h};
            LHU:     data = {{(DATA_WIDTH-16){1'b0}}, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-bus handshake, store lane steering, load alignment,
// misalignment detection and pipeline stall while a transaction is open.
module mem_stage
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] alu_res_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [3:0]            mem_op_i,
    input  logic [4:0]            rd_i,
    input  logic                  rd_we_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  stall_o,
    output logic                  wb_valid_o,
    output logic [4:0]            wb_rd_o,
    output logic                  wb_we_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  exc_misaligned_o,
    output logic                  exc_is_store_o,
    output logic [DATA_WIDTH-1:0] exc_addr_o
);

    mem_state_e            state;
    mem_op_e               op;
    mem_op_e               op_q;
    logic [1:0]            alo_q;
    logic [4:0]            rd_q;
    logic                  we_q;
    logic                  misaligned;
    logic [3:0]            be_calc;
    logic [DATA_WIDTH-1:0] wdata_calc;
    logic [DATA_WIDTH-1:0] ld_data;

    assign op      = mem_op_e'(mem_op_i);
    assign ready_o = (state == IDLE);
    assign stall_o = !ready_o;
    // Request is a pure function of registered state: no gnt->req path.
    assign dmem_req_o = (state == REQ);

    assign misaligned = (is_half(op) && alu_res_i[0]) ||
                        (is_word(op) && (alu_res_i[1:0] != 2'b00));

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = store_data_i;
        if (is_half(op)) begin
            be_calc    = 4'b0011 << {alu_res_i[1], 1'b0};
            wdata_calc = {2{store_data_i[15:0]}};
        end else if (!is_word(op)) begin
            be_calc    = 4'b0001 << alu_res_i[1:0];
            wdata_calc = {4{store_data_i[7:0]}};
        end
    end

    load_align u_load_align (
        .rdata (dmem_rdata_i),
        .addr  (alo_q),
        .op    (op_q),
        .data  (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            op_q             <= NONE;
            alo_q            <= '0;
            rd_q             <= '0;
            we_q             <= 1'b0;
            dmem_we_o        <= 1'b0;
            dmem_addr_o      <= '0;
            dmem_be_o        <= '0;
            dmem_wdata_o     <= '0;
            wb_valid_o       <= 1'b0;
            wb_rd_o          <= '0;
            wb_we_o          <= 1'b0;
            wb_data_o        <= '0;
            exc_misaligned_o <= 1'b0;
            exc_is_store_o   <= 1'b0;
            exc_addr_o       <= '0;
        end else begin
            wb_valid_o       <= 1'b0;
            exc_misaligned_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_i) begin
                        op_q  <= op;
                        alo_q <= alu_res_i[1:0];
                        rd_q  <= rd_i;
                        we_q  <= rd_we_i;
                        if (!is_load(op) && !is_store(op)) begin
                            wb_valid_o <= 1'b1;
                            wb_rd_o    <= rd_i;
                            wb_we_o    <= rd_we_i;
                            wb_data_o  <= alu_res_i;
                        end else if (misaligned) begin
                            wb_valid_o       <= 1'b1;
                            wb_rd_o          <= rd_i;
                            wb_we_o          <= 1'b0;
                            exc_misaligned_o <= 1'b1;
                            exc_is_store_o   <= is_store(op);
                            exc_addr_o       <= alu_res_i;
                        end else begin
                            state        <= REQ;
                            dmem_we_o    <= is_store(op);
                            dmem_addr_o  <= {alu_res_i[ADDR_WIDTH-1:2], 2'b00};
                            dmem_be_o    <= be_calc;
                            dmem_wdata_o <= wdata_calc;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        if (dmem_we_o) begin
                            state      <= IDLE;
                            wb_valid_o <= 1'b1;
                            wb_rd_o    <= rd_q;
                            wb_we_o    <= 1'b0;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dmem_rvalid_i) begin
                        state      <= IDLE;
                        wb_valid_o <= 1'b1;
                        wb_rd_o    <= rd_q;
                        wb_we_o    <= we_q;
                        wb_data_o  <= ld_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks are queued at issue
// and popped by a monitor whenever wb_valid_o fires.
module tb_mem_stage;

    logic        clk = 0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] alu_res_i;
    logic [31:0] store_data_i;
    logic [3:0]  mem_op_i;
    logic [4:0]  rd_i;
    logic        rd_we_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic        wb_we_o;
    logic [31:0] wb_data_o;
    logic        exc_misaligned_o;
    logic        exc_is_store_o;
    logic [31:0] exc_addr_o;

    localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2,
        OP_LW = 4'd3, OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6,
        OP_SH = 4'd7, OP_SW = 4'd8;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
        logic        exc_st;
        logic [31:0] exc_addr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .alu_res_i        (alu_res_i),
        .store_data_i     (store_data_i),
        .mem_op_i         (mem_op_i),
        .rd_i             (rd_i),
        .rd_we_i          (rd_we_i),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_gnt_i       (dmem_gnt_i),
        .dmem_rvalid_i    (dmem_rvalid_i),
        .dmem_rdata_i     (dmem_rdata_i),
        .stall_o          (stall_o),
        .wb_valid_o       (wb_valid_o),
        .wb_rd_o          (wb_rd_o),
        .wb_we_o          (wb_we_o),
        .wb_data_o        (wb_data_o),
        .exc_misaligned_o (exc_misaligned_o),
        .exc_is_store_o   (exc_is_store_o),
        .exc_addr_o       (exc_addr_o)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid_o) begin
            if (q.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("wb_we", {31'd0, wb_we_o}, {31'd0, e.we});
                check("exc_mis", {31'd0, exc_misaligned_o}, {31'd0, e.exc});
                if (e.exc) begin
                    check("exc_st", {31'd0, exc_is_store_o}, {31'd0, e.exc_st});
                    check("exc_addr", exc_addr_o, e.exc_addr);
                end else begin
                    check("wb_rd", {27'd0, wb_rd_o}, {27'd0, e.rd});
                    if (e.we) check("wb_data", wb_data_o, e.data);
                end
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic [4:0] rd,
                        input logic we, input logic exc, input logic st,
                        input logic [31:0] ea);
        exp_t e;
        e.data = d; e.rd = rd; e.we = we;
        e.exc = exc; e.exc_st = st; e.exc_addr = ea;
        q.push_back(e);
    endtask

    // Issue one instruction and play the bus side; kind: 0 none/exc, 1 store, 2 load
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd,
                         input logic we, input int kind, input int gwait,
                         input logic [31:0] rdata, input logic [3:0] xbe,
                         input logic [31:0] xwd);
        int n = 0;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("ready_timeout", 32'd0, 32'd1);
        valid_i = 1; mem_op_i = op; alu_res_i = addr;
        store_data_i = sd; rd_i = rd; rd_we_i = we;
        @(posedge clk); #1;
        valid_i = 0;
        if (kind == 0) begin
            @(negedge clk);
            check("no_req", {31'd0, dmem_req_o}, 32'd0);
            return;
        end
        for (int i = 0; i < gwait; i++) begin
            @(negedge clk);
            check("req_hold", {31'd0, dmem_req_o}, 32'd1);
            check("stall", {31'd0, stall_o}, 32'd1);
            check("addr", dmem_addr_o, {addr[31:2], 2'b00});
            check("be", {28'd0, dmem_be_o}, {28'd0, xbe});
            if (kind == 1) check("wdata", dmem_wdata_o, xwd);
            @(posedge clk);
        end
        @(negedge clk);
        check("req", {31'd0, dmem_req_o}, 32'd1);
        check("be_g", {28'd0, dmem_be_o}, {28'd0, xbe});
        check("we_bus", {31'd0, dmem_we_o}, {31'd0, kind == 1});
        if (kind == 1) check("wdata_g", dmem_wdata_o, xwd);
        dmem_gnt_i = 1;
        @(posedge clk); #1;
        dmem_gnt_i = 0;
        if (kind == 2) begin
            @(negedge clk);
            check("resp_noreq", {31'd0, dmem_req_o}, 32'd0);
            check("resp_busy", {31'd0, ready_o}, 32'd0);
            dmem_rvalid_i = 1; dmem_rdata_i = rdata;
            @(posedge clk); #1;
            dmem_rvalid_i = 0;
        end
        @(negedge clk);
        check("ready_after", {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        rst = 1; valid_i = 0; alu_res_i = 0; store_data_i = 0;
        mem_op_i = 0; rd_i = 0; rd_we_i = 0;
        dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_req", {31'd0, dmem_req_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_wbv", {31'd0, wb_valid_o}, 32'd0);
        rst = 0;

        push(32'h1234, 5'd5, 1, 0, 0, 0);
        do_op(OP_NONE, 32'h1234, 0, 5'd5, 1, 0, 0, 0, 0, 0);
        push(32'h0, 5'd7, 0, 0, 0, 0);
        do_op(OP_SW, 32'h100, 32'hDEADBEEF, 5'd7, 0, 1, 3, 0,
              4'b1111, 32'hDEADBEEF);
        push(32'hFFFFFF80, 5'd3, 1, 0, 0, 0);
        do_op(OP_LB, 32'h203, 0, 5'd3, 1, 2, 1, 32'h80FF0000, 4'b1000, 0);
        push(32'h00000080, 5'd4, 1, 0, 0, 0);
        do_op(OP_LBU, 32'h203, 0, 5'd4, 1, 2, 0, 32'h80FF0000, 4'b1000, 0);
        push(32'hFFFF8001, 5'd6, 1, 0, 0, 0);
        do_op(OP_LH, 32'h202, 0, 5'd6, 1, 2, 0, 32'h80010000, 4'b1100, 0);
        push(32'h00008001, 5'd8, 1, 0, 0, 0);
        do_op(OP_LHU, 32'h202, 0, 5'd8, 1, 2, 2, 32'h80010000, 4'b1100, 0);
        push(32'h0000007F, 5'd9, 1, 0, 0, 0);
        do_op(OP_LB, 32'h200, 0, 5'd9, 1, 2, 0, 32'h1234567F, 4'b0001, 0);
        push(32'hCAFEF00D, 5'd0, 1, 0, 0, 0);
        do_op(OP_LW, 32'h204, 0, 5'd0, 1, 2, 0, 32'hCAFEF00D, 4'b1111, 0);
        push(0, 5'd1, 0, 1, 1, 32'h101);
        do_op(OP_SH, 32'h101, 32'h5555, 5'd1, 0, 0, 0, 0, 0, 0);
        push(0, 5'd2, 0, 1, 0, 32'h102);
        do_op(OP_LW, 32'h102, 0, 5'd2, 1, 0, 0, 0, 0, 0);
        push(0, 5'd0, 0, 0, 0, 0);
        do_op(OP_SB, 32'h3, 32'hAB, 5'd0, 0, 1, 0, 0, 4'b1000, 32'hABABABAB);
        push(0, 5'd0, 0, 0, 0, 0);
        do_op(OP_SH, 32'h102, 32'h1234BEEF, 5'd0, 0, 1, 1, 0,
              4'b1100, 32'hBEEFBEEF);
        push(32'h77, 5'd11, 1, 0, 0, 0);
        do_op(OP_NONE, 32'h77, 0, 5'd11, 1, 0, 0, 0, 0, 0);

        // Stray rvalid while idle must not produce a writeback.
        @(negedge clk);
        dmem_rvalid_i = 1; dmem_rdata_i = 32'h1;
        @(posedge clk); #1;
        dmem_rvalid_i = 0;
        @(negedge clk);
        check("idle_rvalid", {31'd0, wb_valid_o}, 32'd0);

        // Reset while a load waits for its response.
        valid_i = 1; mem_op_i = OP_LW; alu_res_i = 32'h300; rd_i = 5'd12;
        rd_we_i = 1;
        @(posedge clk); #1;
        valid_i = 0; dmem_gnt_i = 1;
        @(posedge clk); #1;
        dmem_gnt_i = 0;
        @(negedge clk);
        check("resp_state", {31'd0, ready_o}, 32'd0);
        rst = 1;
        #1;
        check("mrst_ready", {31'd0, ready_o}, 32'd1);
        check("mrst_req", {31'd0, dmem_req_o}, 32'd0);
        check("mrst_addr", dmem_addr_o, 32'd0);
        check("mrst_be", {28'd0, dmem_be_o}, 32'd0);
        check("mrst_wbv", {31'd0, wb_valid_o}, 32'd0);
        @(negedge clk);
        rst = 0;
        dmem_rvalid_i = 1; dmem_rdata_i = 32'h5A5A5A5A;
        @(posedge clk); #1;
        dmem_rvalid_i = 0;
        @(negedge clk);
        check("stray_rvalid", {31'd0, wb_valid_o}, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
